// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the pipeline stage registers and the hazard unit.
//   PC_W, TNEW_W  : default widths of the PC and Tnew sideband fields
//   stage_side_t  : the sideband bundle carried with every instruction
//   tnew_dec()    : saturating Tnew decrement applied when a stage captures
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int PC_W   = 32;
  localparam int TNEW_W = 2;

  // Hazard/exception sideband that travels alongside the opaque payload.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [TNEW_W-1:0] tnew;
    logic              bd;
  } stage_side_t;

  // Tnew counts the stages left until a result is produced. It drops by one
  // per stage and sticks at zero once the value is available. The argument
  // is an int so callers with any field width can share this function.
  function automatic int unsigned tnew_dec(input int unsigned tnew);
    return (tnew == 0) ? 0 : tnew - 1;
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid_if
// Bundle of every handshake, payload and control signal of one stage.
//   in_*      : upstream beat (valid/ready + data, pc, tnew, bd)
//   out_*     : downstream beat (valid/ready + data, pc, tnew, bd)
//   flush     : kill held entries at the next edge
//   bubble    : refuse input this cycle
//   occupancy : number of valid entries held (0..2)
// Modports:
//   slave  : the view of the stage register itself
//   master : the view of the surrounding pipeline driving the stage
// ---------------------------------------------------------------------------
interface pipe_stage_skid_if #(
  parameter int DATA_W = 128,
  parameter int PC_W   = pipe_pkg::PC_W,
  parameter int TNEW_W = pipe_pkg::TNEW_W
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [PC_W-1:0]   in_pc;
  logic [TNEW_W-1:0] in_tnew;
  logic              in_bd;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [PC_W-1:0]   out_pc;
  logic [TNEW_W-1:0] out_tnew;
  logic              out_bd;

  logic              flush;
  logic              bubble;
  logic [1:0]        occupancy;

  modport slave (
    input  in_valid, in_data, in_pc, in_tnew, in_bd,
    input  out_ready, flush, bubble,
    output in_ready,
    output out_valid, out_data, out_pc, out_tnew, out_bd,
    output occupancy
  );

  modport master (
    output in_valid, in_data, in_pc, in_tnew, in_bd,
    output out_ready, flush, bubble,
    input  in_ready,
    input  out_valid, out_data, out_pc, out_tnew, out_bd,
    input  occupancy
  );

endinterface

// File: rtl/pipe_entry_reg.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline entry: a valid bit plus payload and sideband fields.
//   clk, reset     : clock, asynchronous active-low reset
//   load           : capture d_* and mark the entry valid
//   clear          : mark the entry invalid; data and tnew go to zero while
//                    pc/bd take clr_pc/clr_bd (lets a dead head keep an EPC)
//   d_*            : fields loaded on load
//   clr_pc, clr_bd : pc/bd left behind on clear
//   q_*            : stored entry
// clear wins over load; the parent never asserts both.
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int DATA_W = 128,
  parameter int PC_W   = pipe_pkg::PC_W,
  parameter int TNEW_W = pipe_pkg::TNEW_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d_data,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [TNEW_W-1:0] d_tnew,
  input  logic              d_bd,
  input  logic [PC_W-1:0]   clr_pc,
  input  logic              clr_bd,
  output logic              q_valid,
  output logic [DATA_W-1:0] q_data,
  output logic [PC_W-1:0]   q_pc,
  output logic [TNEW_W-1:0] q_tnew,
  output logic              q_bd
);

  // NOTE: non-blocking assignments keep every register updating from the
  // pre-edge values, so the H <- S transfer in the parent never races.
  // NOTE: these are a handful of flops, not a RAM, so every field is reset;
  // the outputs are visible ports and must never show X after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_pc    <= '0;
      q_tnew  <= '0;
      q_bd    <= 1'b0;
    end else if (clear) begin
      q_valid <= 1'b0;
      q_data  <= '0;
      q_tnew  <= '0;
      q_pc    <= clr_pc;
      q_bd    <= clr_bd;
    end else if (load) begin
      q_valid <= 1'b1;
      q_data  <= d_data;
      q_pc    <= d_pc;
      q_tnew  <= d_tnew;
      q_bd    <= d_bd;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// ---------------------------------------------------------------------------
// pipe_stage_skid
// Generic pipeline stage register with a valid/ready handshake and a 2-entry
// skid buffer (head H + skid S), so back-pressure never drops or duplicates
// an instruction. Used between every pair of stages (D/E, E/M, M/W).
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : pipe_stage_skid_if.slave
//            in_*  upstream beat, in_ready = ~S_v & ~bubble
//            out_* head entry H, out_valid = H_v
//            flush kills H and S at the next edge (an out_fire that cycle
//                  still completes); bubble refuses input for the cycle
//            occupancy = H_v + S_v
// Tnew is decremented (saturating at 0) as a beat is captured.
// KEEP_PC_ON_BUBBLE = 1 leaves a meaningful PC/bd on an invalid head so the
// exception unit can still report an EPC; 0 zeroes them instead.
// ---------------------------------------------------------------------------
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W            = 128,
  parameter int PC_W              = pipe_pkg::PC_W,
  parameter int TNEW_W            = pipe_pkg::TNEW_W,
  parameter bit KEEP_PC_ON_BUBBLE = 1'b1
) (
  input logic                   clk,
  input logic                   reset,
  pipe_stage_skid_if.slave      bus
);

  // Head entry (drives the outputs) and skid entry.
  logic              h_v, s_v;
  logic [DATA_W-1:0] h_data, s_data;
  logic [PC_W-1:0]   h_pc, s_pc;
  logic [TNEW_W-1:0] h_tnew, s_tnew;
  logic              h_bd, s_bd;

  // Per-edge control produced by the next-state logic.
  logic              h_load, h_clear, h_from_skid;
  logic              s_load, s_clear;
  logic [PC_W-1:0]   h_clr_pc;
  logic              h_clr_bd;

  logic              in_fire, out_fire;

  // Captured form of the upstream beat.
  logic [TNEW_W-1:0] cap_tnew;

  // Head load mux: the skid entry when draining S, otherwise the input.
  logic [DATA_W-1:0] h_d_data;
  logic [PC_W-1:0]   h_d_pc;
  logic [TNEW_W-1:0] h_d_tnew;
  logic              h_d_bd;

  // in_ready depends only on registered state and bubble, never on
  // in_valid or out_ready, so no combinational path crosses the stage.
  assign bus.in_ready = ~s_v & ~bus.bubble;
  assign in_fire      = bus.in_valid & bus.in_ready;
  assign out_fire     = h_v & bus.out_ready;

  assign cap_tnew = TNEW_W'(tnew_dec(32'(bus.in_tnew)));

  assign h_d_data = h_from_skid ? s_data : bus.in_data;
  assign h_d_pc   = h_from_skid ? s_pc   : bus.in_pc;
  assign h_d_tnew = h_from_skid ? s_tnew : cap_tnew;
  assign h_d_bd   = h_from_skid ? s_bd   : bus.in_bd;

  // NOTE: every signal gets a default before the branches, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    h_load      = 1'b0;
    h_clear     = 1'b0;
    h_from_skid = 1'b0;
    s_load      = 1'b0;
    s_clear     = 1'b0;
    h_clr_pc    = KEEP_PC_ON_BUBBLE ? h_pc : '0;
    h_clr_bd    = KEEP_PC_ON_BUBBLE ? h_bd : 1'b0;

    if (bus.flush) begin
      // Kill both entries; any input this cycle is discarded. The youngest
      // visible PC is left on the dead head as the exception PC.
      h_clear = 1'b1;
      s_clear = 1'b1;
      if (KEEP_PC_ON_BUBBLE) begin
        if (bus.in_valid) begin
          h_clr_pc = bus.in_pc;
          h_clr_bd = bus.in_bd;
        end else if (s_v) begin
          h_clr_pc = s_pc;
          h_clr_bd = s_bd;
        end
      end
    end else if (!h_v) begin
      h_load = in_fire;
    end else if (out_fire) begin
      if (s_v) begin
        // S is older than any input, so it moves up first.
        h_load      = 1'b1;
        h_from_skid = 1'b1;
        s_clear     = 1'b1;
      end else if (in_fire) begin
        h_load = 1'b1;
      end else begin
        h_clear = 1'b1;
      end
    end else begin
      // Head is stalled; an accepted beat can only mean S is empty.
      s_load = in_fire;
    end
  end

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .TNEW_W (TNEW_W)
  ) u_head (
    .clk     (clk),
    .reset   (reset),
    .load    (h_load),
    .clear   (h_clear),
    .d_data  (h_d_data),
    .d_pc    (h_d_pc),
    .d_tnew  (h_d_tnew),
    .d_bd    (h_d_bd),
    .clr_pc  (h_clr_pc),
    .clr_bd  (h_clr_bd),
    .q_valid (h_v),
    .q_data  (h_data),
    .q_pc    (h_pc),
    .q_tnew  (h_tnew),
    .q_bd    (h_bd)
  );

  pipe_entry_reg #(
    .DATA_W (DATA_W),
    .PC_W   (PC_W),
    .TNEW_W (TNEW_W)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load    (s_load),
    .clear   (s_clear),
    .d_data  (bus.in_data),
    .d_pc    (bus.in_pc),
    .d_tnew  (cap_tnew),
    .d_bd    (bus.in_bd),
    .clr_pc  ('0),
    .clr_bd  (1'b0),
    .q_valid (s_v),
    .q_data  (s_data),
    .q_pc    (s_pc),
    .q_tnew  (s_tnew),
    .q_bd    (s_bd)
  );

  assign bus.out_valid = h_v;
  assign bus.out_data  = h_data;
  assign bus.out_pc    = h_pc;
  assign bus.out_tnew  = h_tnew;
  assign bus.out_bd    = h_bd;
  assign bus.occupancy = {1'b0, h_v} + {1'b0, s_v};

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed ID/EX-style stage registers.
- One generic pipeline stage register with a valid/ready handshake and a 2-entry skid buffer, so back-pressure never drops or duplicates an instruction.
- Carries a payload bundle plus three hazard/exception sideband fields: PC, Tnew and branch-delay flag (bd).
- Tnew is decremented automatically on capture.
- Supports flush (kill in-flight entries) and bubble insertion. The bubble keeps the PC so the exception unit can still report an EPC.
- Instantiated between every pair of stages (D/E, E/M, M/W).

Parameters:
- DATA_W, 128, width of the opaque payload (control + operands).
- PC_W, 32, width of the PC sideband.
- TNEW_W, 2, width of the Tnew field.
- KEEP_PC_ON_BUBBLE, 1, when 1 a flushed or empty head keeps a valid PC for exception reporting; when 0 PC clears to 0 on flush.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream beat present
- in_ready  out  1  stage can accept; equals ~skid_v & ~bubble
- in_data  in  DATA_W  payload
- in_pc  in  PC_W  instruction PC
- in_tnew  in  TNEW_W  Tnew at the upstream stage
- in_bd  in  1  instruction is in a branch-delay slot
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  head payload
- out_pc  out  PC_W  head PC
- out_tnew  out  TNEW_W  head Tnew
- out_bd  out  1  head bd flag
- flush  in  1  kill all held entries at the next edge
- bubble  in  1  refuse input this cycle (stall insertion)
- occupancy  out  2  number of valid entries, 0..2

Behaviour:
- Storage:
  - Head register H (drives the out_* ports) and skid register S, each with its own valid bit.
  - H_v and S_v are registered. out_valid = H_v. occupancy = H_v + S_v.
- Handshake events:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
  - in_ready is combinational from S_v and bubble only; it never depends on in_valid or out_ready.
- Tnew on capture: stored tnew = (in_tnew == 0) ? 0 : in_tnew - 1, saturating. Data, pc and bd are stored unchanged.
- Next-state rules when flush = 0, evaluated on each clock edge:
  - H empty: if in_fire, H <= captured input.
  - H valid and out_fire:
    - if S_v, H <= S and S_v <= 0;
    - else if in_fire, H <= captured input;
    - else H_v <= 0.
  - H valid, no out_fire, in_fire: S <= captured input and S_v <= 1. This is only reachable when S is empty.
  - Ordering is strictly first-in first-out; S never overtakes H.
- Flush = 1 (highest priority):
  - out_fire in the same cycle still completes; downstream keeps that beat.
  - On the next edge H_v <= 0 and S_v <= 0. An in_fire in the same cycle is discarded.
  - With KEEP_PC_ON_BUBBLE = 1: H_pc <= in_valid ? in_pc : (S_v ? S_pc : H_pc), and H_bd follows the same source.
  - With KEEP_PC_ON_BUBBLE = 0: H_pc <= 0 and H_bd <= 0.
  - Tnew and data of an invalid head are 0.
- Bubble = 1: no input is accepted; the head and skid drain normally.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Throughput is 1 beat per cycle when out_ready = 1.
- Reset (asynchronous, any time, including mid-transfer): H_v = S_v = 0, all stored fields = 0. After reset, out_valid = 0, occupancy = 0, and in_ready = ~bubble.
- Invariants:
  - S_v implies H_v.
  - occupancy never exceeds 2.
  - No beat is lost or duplicated unless flush is asserted.

Decomposition:
- Shared package pipe_pkg holds:
  - the constants PC_W and TNEW_W;
  - the typedef stage_side_t {pc, tnew, bd};
  - the function tnew_dec(), used here and in the hazard unit.
- One natural sub-module: pipe_entry_reg, one valid+data+sideband register with load and clear, instantiated twice for H and S.

Test Plan:
- Stream with out_ready = 1: in_tnew = 2, then 1, then 0 on consecutive cycles -> 1 cycle later out_tnew = 1, 0, 0; occupancy stays at 1.
- Back-pressure: beats A, B, C presented while out_ready = 0:
  - A lands in H and B lands in S; in_ready drops to 0 after B; C is held upstream.
  - Raise out_ready -> outputs in order A, B, C with no gaps once flowing.
- Flush with H = A (pc 0x3000) and S = B, in_valid = 1 with pc 0x3008, out_ready = 0:
  - next cycle out_valid = 0, occupancy = 0, out_pc = 0x3008 (KEEP_PC_ON_BUBBLE = 1).
  - Repeat with the parameter set to 0 -> out_pc = 0.
- Bubble held for 3 cycles with in_valid = 1 and out_ready = 1 -> in_ready = 0; the head drains; out_valid = 0 for 3 cycles; the upstream beat enters on cycle 4.
- Flush and out_fire in the same cycle: the head beat is counted once downstream and the skid entry is killed; a scoreboard shows no duplication.
- reset low asynchronously mid-stream between clock edges -> out_valid = 0 and occupancy = 0 immediately; after release a single beat passes with 1-cycle latency.
